// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: grants one requester at a time for up to its
// programmed number of beats, with a mandatory idle cycle between grants.
module wrr_arbiter #(
    parameter int N  = 8,
    parameter int WW = 3,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_id
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          fsm_r;
    logic [IW-1:0]   ptr_r;
    logic [WW-1:0]   credit_r;
    logic [N-1:0]    grant_r;
    logic            grant_valid_r;
    logic [IW-1:0]   grant_id_r;

    logic [IW-1:0]   win_idx_s;
    logic [WW-1:0]   win_weight_s;
    logic [WW-1:0]   win_credit_s;
    logic [IW-1:0]   ptr_next_s;
    logic            owner_req_s;

    // First requester found scanning circularly from the start index p.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] pick;
        logic [IW:0]   sum;
        logic          found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, p} + (IW+1)'(k);
            sum = (sum >= (IW+1)'(N)) ? (sum - (IW+1)'(N)) : sum;
            if (!found && r[sum[IW-1:0]]) begin
                pick  = sum[IW-1:0];
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    // Winner selection, its quota (0 counts as 1) and the post-release pointer.
    always_comb begin
        win_idx_s    = rr_pick(req, ptr_r);
        win_weight_s = '0;
        for (int j = 0; j < N; j++) begin
            win_weight_s = (IW'(j) == win_idx_s) ? weight[j*WW +: WW] : win_weight_s;
        end
        if (win_weight_s == '0) begin
            win_credit_s = WW'(1);
        end else begin
            win_credit_s = win_weight_s;
        end
        if (grant_id_r == IW'(N-1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = grant_id_r + IW'(1);
        end
        owner_req_s = req[grant_id_r];
    end

    // Arbitration FSM with registered grant outputs; grant_id doubles as owner.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_r         <= IDLE;
            ptr_r         <= '0;
            credit_r      <= '0;
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            grant_id_r    <= '0;
        end else begin
            case (fsm_r)
                IDLE: begin
                    if (|req) begin
                        fsm_r         <= GRANT;
                        grant_r       <= N'(1) << win_idx_s;
                        grant_valid_r <= 1'b1;
                        grant_id_r    <= win_idx_s;
                        credit_r      <= win_credit_s;
                    end
                end
                GRANT: begin
                    // Release on the last beat or as soon as the owner lets go.
                    if (owner_req_s && (credit_r > WW'(1))) begin
                        credit_r <= credit_r - WW'(1);
                    end else begin
                        fsm_r         <= IDLE;
                        grant_r       <= '0;
                        grant_valid_r <= 1'b0;
                        ptr_r         <= ptr_next_s;
                    end
                end
                default: begin
                    fsm_r         <= IDLE;
                    grant_r       <= '0;
                    grant_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_id    = grant_id_r;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter in the 8-requester, 3-bit weight configuration.
module tb_wrr_arbiter;

    localparam int N  = 8;
    localparam int WW = 3;
    localparam int IW = 3;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    grant;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;

    int tests_run    = 0;
    int tests_failed = 0;

    wrr_arbiter #(.N(N), .WW(WW), .IW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .weight      (weight),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_weight(input int i, input logic [WW-1:0] v);
        weight[i*WW +: WW] = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        step();
        rst = 1'b0;
    endtask

    task automatic check_grant(input string name, input int cyc, input logic [N-1:0] exp);
        tests_run++;
        if ((grant !== exp) || (grant_valid !== (|exp))) begin
            $display("FAIL %s cycle %0d: grant=%h valid=%b, expected grant=%h valid=%b",
                     name, cyc, grant, grant_valid, exp, |exp);
            tests_failed++;
        end
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        req    = 8'h00;
        weight = 24'o11111111;
        step();
        step();
        check_grant("reset_initial", 0, 8'h00);
        tests_run++;
        if (grant_id !== 3'd0) begin
            $display("FAIL reset_initial_id: grant_id=%0d, expected 0", grant_id);
            tests_failed++;
        end
        rst = 1'b0;
        req = 8'hFF;
        step();
        check_grant("reset_first_grant", 1, 8'h01);
        step();
        step();
        check_grant("reset_pre_async", 3, 8'h02);
        // Assert reset between edges; outputs must clear without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check_grant("reset_async", 4, 8'h00);
        tests_run++;
        if (grant_id !== 3'd0) begin
            $display("FAIL reset_async_id: grant_id=%0d, expected 0", grant_id);
            tests_failed++;
        end
        step();
        rst = 1'b0;
        step();
        check_grant("reset_release_grant", 5, 8'h01);
        tests_run++;
        if (grant_id !== 3'd0) begin
            $display("FAIL reset_release_id: grant_id=%0d, expected 0", grant_id);
            tests_failed++;
        end
    endtask

    task automatic test_rotation();
        do_reset();
        weight = 24'o11111111;
        req    = 8'hFF;
        for (int i = 0; i <= N; i++) begin
            step();
            check_grant("rotation_grant", i, 8'h01 << (i % N));
            tests_run++;
            if (grant_id !== IW'(i % N)) begin
                $display("FAIL rotation_id step %0d: grant_id=%0d, expected %0d", i, grant_id, i % N);
                tests_failed++;
            end
            step();
            check_grant("rotation_gap", i, 8'h00);
        end
    endtask

    task automatic test_weighting();
        logic [N-1:0] exp_seq [7];
        exp_seq = '{8'h01, 8'h01, 8'h01, 8'h00, 8'h20, 8'h00, 8'h01};
        do_reset();
        weight = 24'o11111111;
        set_weight(0, 3'd3);
        set_weight(5, 3'd1);
        req = 8'h21;
        for (int i = 0; i < 7; i++) begin
            step();
            check_grant("weighting", i, exp_seq[i]);
        end
    endtask

    task automatic test_early_release();
        do_reset();
        weight = 24'o11111111;
        set_weight(2, 3'd7);
        req = 8'h04;
        step();
        check_grant("early_release_start", 0, 8'h04);
        step();
        check_grant("early_release_hold", 1, 8'h04);
        req = 8'h00;
        step();
        check_grant("early_release_drop", 2, 8'h00);
        req = 8'h0A;
        step();
        check_grant("early_release_next", 3, 8'h08);
        tests_run++;
        if (grant_id !== 3'd3) begin
            $display("FAIL early_release_next_id: grant_id=%0d, expected 3", grant_id);
            tests_failed++;
        end
    endtask

    task automatic test_zero_weight_wrap();
        do_reset();
        weight = 24'o11111111;
        set_weight(7, 3'd0);
        req = 8'h40;
        step();
        check_grant("wrap_setup", 0, 8'h40);
        req = 8'h00;
        step();
        check_grant("wrap_setup_idle", 1, 8'h00);
        req = 8'h81;
        step();
        check_grant("wrap_zero_weight", 2, 8'h80);
        step();
        check_grant("wrap_zero_weight_end", 3, 8'h00);
        step();
        check_grant("wrap_to_zero", 4, 8'h01);
        tests_run++;
        if (grant_id !== 3'd0) begin
            $display("FAIL wrap_to_zero_id: grant_id=%0d, expected 0", grant_id);
            tests_failed++;
        end
    endtask

    task automatic test_weight_change();
        logic [N-1:0] exp_seq [9];
        exp_seq = '{8'h10, 8'h00, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h00};
        do_reset();
        weight = 24'o11111111;
        set_weight(4, 3'd2);
        req = 8'h10;
        step();
        check_grant("weight_change_start", 0, 8'h10);
        // Quota was captured at grant time; the new value applies to the next grant.
        set_weight(4, 3'd6);
        for (int i = 0; i < 9; i++) begin
            step();
            check_grant("weight_change", i + 1, exp_seq[i]);
        end
    endtask

    initial begin
        rst    = 1'b1;
        req    = 8'h00;
        weight = 24'o11111111;
        test_reset();
        test_rotation();
        test_weighting();
        test_early_release();
        test_zero_weight_wrap();
        test_weight_change();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
